// File: rtl/clk_en_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_gen_pkg
//
// Purpose:
//   Shared constants for the clock-enable generator: default parameter values
//   for the top, the width of the frame position counter derived from the
//   frame length, and the width of the optional frame counter output.
//
// Contents:
//   NUM_POW2_DEF     default number of fixed power-of-two strobes
//   CNT_W_DEF        default programmable divider width
//   FRAME_LEN_DEF    default number of div_en ticks per frame
//   cnt_width()      bits needed to count 0..n-1 (never less than 1)
//   FRAME_CNT_W_DEF  frame position counter width for FRAME_LEN_DEF
//   FRAME_COUNT_W    width of the optional frame_count output
// -----------------------------------------------------------------------------
package clk_en_gen_pkg;

    localparam int NUM_POW2_DEF  = 4;
    localparam int CNT_W_DEF     = 8;
    localparam int FRAME_LEN_DEF = 64;

    // Width of a counter that must hold 0..n-1. A frame of 2 still needs one
    // bit, so the result is clamped to at least 1.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    localparam int FRAME_CNT_W_DEF = cnt_width(FRAME_LEN_DEF);

    // Frame counter wraps naturally at 0xFFFF -> 0.
    localparam int FRAME_COUNT_W = 16;

endpackage : clk_en_gen_pkg

// File: rtl/clk_en_divider.sv
// -----------------------------------------------------------------------------
// clk_en_divider
//
// Purpose:
//   Runtime-programmable clock-enable divider. A counter runs 0..div_active and
//   a tick is raised whenever the counter reads 0 while running. The requested
//   divisor is copied into the shadow div_active only when the counter wraps
//   (or on a synchronous clear), so changing div mid-period never shortens or
//   stretches the period in progress. Ratio is div_active+1; div_active==0
//   yields a tick on every running cycle.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   run_i         1 = counter advances, 0 = hold
//   sync_clr_i    synchronous realign: counter to 0, shadow loads div_i
//   div_i         requested divide value minus one
//   tick_o        combinational: counter is 0 this cycle and it will advance
//   div_en_o      registered single-cycle strobe (tick delayed one cycle)
//   div_active_o  divisor currently in use (shadow register)
// -----------------------------------------------------------------------------
module clk_en_divider #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             sync_clr_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             tick_o,
    output logic             div_en_o,
    output logic [CNT_W-1:0] div_active_o
);

    logic [CNT_W-1:0] div_cnt_q,    div_cnt_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic             div_en_q,     div_en_d;

    // sync_clr wins over run, so a clearing cycle never produces a tick.
    assign tick_o = run_i && !sync_clr_i && (div_cnt_q == '0);

    always_comb begin
        div_cnt_d    = div_cnt_q;
        div_active_d = div_active_q;
        div_en_d     = 1'b0;

        if (sync_clr_i) begin
            div_cnt_d    = '0;
            div_active_d = div_i;
        end else if (run_i) begin
            div_en_d = tick_o;
            // Wrap point: this is the only place a new divisor is accepted.
            // The value present at this edge is the one taken.
            if (div_cnt_q == div_active_q) begin
                div_cnt_d    = '0;
                div_active_d = div_i;
            end else begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q    <= '0;
            div_active_q <= '0;
            div_en_q     <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            div_active_q <= div_active_d;
            div_en_q     <= div_en_d;
        end
    end

    assign div_en_o     = div_en_q;
    assign div_active_o = div_active_q;

endmodule : clk_en_divider

// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen
//
// Purpose:
//   Audio-path clock-enable generator. All outputs are registered and
//   synchronous to clk. It produces:
//     - a bank of fixed power-of-two strobes (bit k divides by 2^(k+1));
//     - a programmable divider strobe (div_en) with a bit-clock level
//       (sclk_lvl) that toggles on every div_en tick;
//     - a frame strobe (frame_en) on the first tick of each FRAME_LEN-tick
//       frame, plus an LR-phase level (frame_phase) for I2S framing.
//   run=0 freezes every counter and level; strobes drop to 0 the next cycle.
//   sync_clr (priority over run) realigns all phases: the cycle after it,
//   every counter and level is 0, and the next running edge fires div_en,
//   frame_en and every pow2_en together.
//
// Optional feature (macro CLK_EN_GEN_FRAME_CNT_EN):
//   When defined, adds a 16-bit frame_count output that increments on every
//   frame_en assertion, wraps at 0xFFFF, and is cleared by reset and sync_clr.
//   When undefined, the port and its counter do not exist.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset (release synchronised outside)
//   run          1 = counters advance, 0 = hold
//   sync_clr     single-cycle synchronous phase realign
//   div          requested divide value minus one
//   pow2_en      fixed power-of-two strobes
//   div_en       programmable strobe
//   sclk_lvl     bit-clock level, toggles on every div_en tick
//   frame_en     strobe on the first tick of each frame
//   frame_phase  0 = first half of frame, 1 = second half
//   div_active   divisor currently in use
//   frame_count  (optional) number of frames started, modulo 2^16
// -----------------------------------------------------------------------------
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int NUM_POW2  = NUM_POW2_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic                     sync_clr,
    input  logic [CNT_W-1:0]         div,
    output logic [NUM_POW2-1:0]      pow2_en,
    output logic                     div_en,
    output logic                     sclk_lvl,
    output logic                     frame_en,
    output logic                     frame_phase,
    output logic [CNT_W-1:0]         div_active
`ifdef CLK_EN_GEN_FRAME_CNT_EN
    ,
    output logic [FRAME_COUNT_W-1:0] frame_count
`endif
);

    localparam int FRAME_CNT_W = cnt_width(FRAME_LEN);

    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_LEN - 1);
    localparam logic [FRAME_CNT_W-1:0] FRAME_HALF = FRAME_CNT_W'(FRAME_LEN / 2);

    // -------------------------------------------------------------------------
    // Programmable divider
    // -------------------------------------------------------------------------
    logic tick;

    clk_en_divider #(
        .CNT_W (CNT_W)
    ) u_divider (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .run_i        (run),
        .sync_clr_i   (sync_clr),
        .div_i        (div),
        .tick_o       (tick),
        .div_en_o     (div_en),
        .div_active_o (div_active)
    );

    // -------------------------------------------------------------------------
    // Fixed power-of-two bank
    // -------------------------------------------------------------------------
    logic [NUM_POW2-1:0] p_q,       p_d;
    logic [NUM_POW2-1:0] pow2_en_q, pow2_en_d;
    logic [NUM_POW2-1:0] pow2_hit;

    // Bit k fires when the low k+1 bits of the free counter are all zero,
    // i.e. once every 2^(k+1) running cycles.
    for (genvar k = 0; k < NUM_POW2; k++) begin : g_pow2_hit
        assign pow2_hit[k] = ~|p_q[k:0];
    end

    always_comb begin
        p_d       = p_q;
        pow2_en_d = '0;

        if (sync_clr) begin
            p_d = '0;
        end else if (run) begin
            p_d       = p_q + NUM_POW2'(1);
            pow2_en_d = pow2_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q       <= '0;
            pow2_en_q <= '0;
        end else begin
            p_q       <= p_d;
            pow2_en_q <= pow2_en_d;
        end
    end

    assign pow2_en = pow2_en_q;

    // -------------------------------------------------------------------------
    // Frame position, frame strobe and level outputs
    // -------------------------------------------------------------------------
    logic [FRAME_CNT_W-1:0] frame_cnt_q,   frame_cnt_d;
    logic                   frame_en_q,    frame_en_d;
    logic                   frame_phase_q, frame_phase_d;
    logic                   sclk_lvl_q,    sclk_lvl_d;
    logic                   frame_start;

    // A tick taken while the position reads 0 starts a new frame.
    assign frame_start = tick && (frame_cnt_q == '0);

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        frame_en_d    = 1'b0;
        frame_phase_d = frame_phase_q;
        sclk_lvl_d    = sclk_lvl_q;

        if (sync_clr) begin
            frame_cnt_d   = '0;
            frame_phase_d = 1'b0;
            sclk_lvl_d    = 1'b0;
        end else if (tick) begin
            frame_en_d    = frame_start;
            frame_phase_d = (frame_cnt_q >= FRAME_HALF);
            sclk_lvl_d    = ~sclk_lvl_q;
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            frame_en_q    <= 1'b0;
            frame_phase_q <= 1'b0;
            sclk_lvl_q    <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            frame_en_q    <= frame_en_d;
            frame_phase_q <= frame_phase_d;
            sclk_lvl_q    <= sclk_lvl_d;
        end
    end

    assign frame_en    = frame_en_q;
    assign frame_phase = frame_phase_q;
    assign sclk_lvl    = sclk_lvl_q;

    // -------------------------------------------------------------------------
    // Optional running frame counter
    // -------------------------------------------------------------------------
`ifdef CLK_EN_GEN_FRAME_CNT_EN
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (sync_clr) begin
            frame_count_d = '0;
        end else if (frame_start) begin
            frame_count_d = frame_count_q + FRAME_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule : clk_en_gen

// File: tb/tb_clk_en_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_en_gen
//
// Bench for clk_en_gen with NUM_POW2=4, CNT_W=8, FRAME_LEN=4. A behavioural
// model tracks running-cycle and tick counts since the last clear and derives
// every output from them with plain arithmetic; one process compares the DUT
// against it on every falling edge. Directed sequences pin the model with
// hand-worked edge numbers, then a randomized run exercises run/sync_clr/div.
// Build with +define+CLK_EN_GEN_FRAME_CNT_EN to include frame_count.
// -----------------------------------------------------------------------------
module tb_clk_en_gen;

  localparam int NP = 4;
  localparam int CW = 8;
  localparam int FL = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          run = 1'b0;
  logic          sync_clr = 1'b0;
  logic [CW-1:0] div = '0;
  logic [NP-1:0] pow2_en;
  logic          div_en;
  logic          sclk_lvl;
  logic          frame_en;
  logic          frame_phase;
  logic [CW-1:0] div_active;
`ifdef CLK_EN_GEN_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  initial forever #5 clk = ~clk;

  clk_en_gen #(
    .NUM_POW2  (NP),
    .CNT_W     (CW),
    .FRAME_LEN (FL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .sync_clr    (sync_clr),
    .div         (div),
    .pow2_en     (pow2_en),
    .div_en      (div_en),
    .sclk_lvl    (sclk_lvl),
    .frame_en    (frame_en),
    .frame_phase (frame_phase),
    .div_active  (div_active)
`ifdef CLK_EN_GEN_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t edge=%0d: got 0x%0h expected 0x%0h", name, $time, edge_n, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: everything follows from how many running cycles and
  // how many ticks have elapsed since the last clear.
  // ---------------------------------------------------------------------------
  int n_run;     // running cycles since clear (pow2 bank)
  int ratio;     // period of the divider period in progress
  int pos;       // running cycles already spent in that period
  int n_tick;    // ticks since clear
  int exp_fc;    // frames started since clear, mod 2^16
  logic [NP-1:0] exp_pow2;
  logic          exp_div_en, exp_sclk, exp_fen, exp_phase;
  logic [CW-1:0] exp_dact;

  task automatic model_reset();
    n_run = 0; ratio = 1; pos = 0; n_tick = 0; exp_fc = 0;
    exp_pow2 = '0; exp_div_en = 1'b0; exp_sclk = 1'b0;
    exp_fen = 1'b0; exp_phase = 1'b0; exp_dact = '0;
  endtask

  task automatic model_edge(input logic r, input logic c, input logic [CW-1:0] d);
    int  idx;
    bit  tk;
    if (c) begin
      n_run = 0; pos = 0; ratio = int'(d) + 1; n_tick = 0; exp_fc = 0;
      exp_pow2 = '0; exp_div_en = 1'b0; exp_fen = 1'b0;
      exp_phase = 1'b0; exp_sclk = 1'b0;
    end else if (!r) begin
      exp_pow2 = '0; exp_div_en = 1'b0; exp_fen = 1'b0;
    end else begin
      for (int k = 0; k < NP; k++) exp_pow2[k] = ((n_run % (1 << (k + 1))) == 0);
      n_run++;
      tk = (pos == 0);
      exp_div_en = tk;
      if (pos == ratio - 1) begin
        pos = 0;
        ratio = int'(d) + 1;
      end else begin
        pos++;
      end
      if (tk) begin
        idx = n_tick % FL;
        exp_fen = (idx == 0);
        exp_phase = (idx >= FL / 2);
        exp_sclk = ((n_tick % 2) == 0);
        if (idx == 0) exp_fc = (exp_fc + 1) % 65536;
        n_tick++;
      end else begin
        exp_fen = 1'b0;
      end
    end
    exp_dact = CW'(ratio - 1);
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: outputs are stable at the falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pow2_en",     32'(pow2_en),     32'(exp_pow2));
      chk("m_div_en",      32'(div_en),      32'(exp_div_en));
      chk("m_sclk_lvl",    32'(sclk_lvl),    32'(exp_sclk));
      chk("m_frame_en",    32'(frame_en),    32'(exp_fen));
      chk("m_frame_phase", 32'(frame_phase), 32'(exp_phase));
      chk("m_div_active",  32'(div_active),  32'(exp_dact));
`ifdef CLK_EN_GEN_FRAME_CNT_EN
      chk("m_frame_count", 32'(frame_count), 32'(exp_fc));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic c, input logic [CW-1:0] d);
    @(negedge clk);
    run = r; sync_clr = c; div = d;
    @(posedge clk);
    model_edge(r, c, d);
    edge_n++;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pow2_en"},     32'(pow2_en),     32'h0);
    chk({tag, "_div_en"},      32'(div_en),      32'h0);
    chk({tag, "_sclk_lvl"},    32'(sclk_lvl),    32'h0);
    chk({tag, "_frame_en"},    32'(frame_en),    32'h0);
    chk({tag, "_frame_phase"}, 32'(frame_phase), 32'h0);
    chk({tag, "_div_active"},  32'(div_active),  32'h0);
`ifdef CLK_EN_GEN_FRAME_CNT_EN
    chk({tag, "_frame_count"}, 32'(frame_count), 32'h0);
`endif
  endtask

  // Assert reset, check the reset state, release just after a rising edge so
  // the next step's edge is edge 1.
  task automatic do_reset(input logic [CW-1:0] d);
    @(negedge clk);
    #1;
    rst_n = 1'b0; run = 1'b0; sync_clr = 1'b0; div = d;
    model_reset();
    #1;
    chk_all_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [CW-1:0] rdiv;
    logic          rr, rc;

    model_reset();
    #1;
    rst_n = 1'b0;
    #2;
    chk_en = 1'b1;

    // A: div=3 held from reset, run=1.
    do_reset(8'd3);
    for (int e = 1; e <= 17; e++) begin
      step(1'b1, 1'b0, 8'd3);
      chk("A_div_en", 32'(div_en), 32'(e == 1 || e == 2 || e == 6 || e == 10 || e == 14));
      chk("A_pow2_0", 32'(pow2_en[0]), 32'(e % 2 == 1));
      chk("A_pow2_1", 32'(pow2_en[1]), 32'(e % 4 == 1));
      chk("A_pow2_3", 32'(pow2_en[3]), 32'(e == 1 || e == 17));
      chk("A_div_active", 32'(div_active), 32'd3);
      if (e == 1) chk("A_sclk_e1", 32'(sclk_lvl), 32'd1);
      if (e == 2) chk("A_sclk_e2", 32'(sclk_lvl), 32'd0);
      if (e == 6) chk("A_sclk_e6", 32'(sclk_lvl), 32'd1);
      if (e == 14) chk("A_frame_en_e14", 32'(frame_en), 32'd1);
    end

    // B: div=0, tick every cycle, FRAME_LEN=4.
    do_reset(8'd0);
    for (int e = 1; e <= 9; e++) begin
      step(1'b1, 1'b0, 8'd0);
      chk("B_frame_en", 32'(frame_en), 32'(e == 1 || e == 5 || e == 9));
      chk("B_frame_phase", 32'(frame_phase), 32'(e == 3 || e == 4 || e == 7 || e == 8));
      chk("B_div_en", 32'(div_en), 32'd1);
`ifdef CLK_EN_GEN_FRAME_CNT_EN
      if (e == 9) chk("B_frame_count_e9", 32'(frame_count), 32'd3);
`endif
    end

    // C: div 3 -> 1 two cycles after the div_en at edge 6.
    do_reset(8'd3);
    for (int e = 1; e <= 15; e++) begin
      step(1'b1, 1'b0, (e >= 8) ? 8'd1 : 8'd3);
      if (e >= 7) chk("C_div_en", 32'(div_en), 32'(e == 10 || e == 12 || e == 14));
      if (e == 8) chk("C_dact_e8", 32'(div_active), 32'd3);
      if (e == 9) chk("C_dact_e9", 32'(div_active), 32'd1);
    end

    // D: run low for 5 cycles mid-period.
    do_reset(8'd3);
    for (int e = 1; e <= 16; e++) begin
      step((e >= 8 && e <= 12) ? 1'b0 : 1'b1, 1'b0, 8'd3);
      chk("D_div_en", 32'(div_en), 32'(e == 1 || e == 2 || e == 6 || e == 15));
      if (e >= 8 && e <= 12) begin
        chk("D_pow2_hold", 32'(pow2_en), 32'h0);
        chk("D_frame_en_hold", 32'(frame_en), 32'h0);
        chk("D_sclk_hold", 32'(sclk_lvl), 32'd1);
      end
    end

    // E: sync_clr mid-frame with run=1.
    do_reset(8'd0);
    for (int e = 1; e <= 7; e++) step(1'b1, 1'b0, 8'd0);
    chk("E_phase_before", 32'(frame_phase), 32'd1);
    step(1'b1, 1'b1, 8'd0);
    chk("E_clr_pow2", 32'(pow2_en), 32'h0);
    chk("E_clr_div_en", 32'(div_en), 32'd0);
    chk("E_clr_frame_en", 32'(frame_en), 32'd0);
    chk("E_clr_phase", 32'(frame_phase), 32'd0);
    chk("E_clr_sclk", 32'(sclk_lvl), 32'd0);
    step(1'b1, 1'b0, 8'd0);
    chk("E_post_pow2", 32'(pow2_en), 32'hF);
    chk("E_post_div_en", 32'(div_en), 32'd1);
    chk("E_post_frame_en", 32'(frame_en), 32'd1);

    // F: asynchronous reset mid-frame, between clock edges.
    do_reset(8'd0);
    for (int e = 1; e <= 7; e++) step(1'b1, 1'b0, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("F_async");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // G: randomized run / sync_clr / div changes.
    do_reset(8'd2);
    rdiv = 8'd2;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 10) begin
        if ($urandom_range(0, 9) == 0) rdiv = CW'($urandom_range(0, 20));
        else rdiv = CW'($urandom_range(0, 6));
      end
      rr = ($urandom_range(0, 99) < 80);
      rc = ($urandom_range(0, 99) < 3);
      step(rr, rc, rdiv);
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_clk_en_gen
